// File: rtl/vm_pkg.sv
// vm_pkg: shared constants, FSM state type and per-beat range limits
// for the vending-machine result frame receiver.
package vm_pkg;
    localparam int FRAME_LEN = 6;
    localparam int NUM_ITEMS = 6;
    localparam logic [9:0] DEN_50 = 10'd50;
    localparam logic [9:0] DEN_20 = 10'd20;
    localparam logic [9:0] DEN_10 = 10'd10;
    localparam logic [9:0] DEN_5  = 10'd5;
    localparam logic [9:0] DEN_1  = 10'd1;
    localparam logic [3:0] MAX_ITEM = 4'd6;
    localparam logic [3:0] MAX_C50  = 4'd10;
    localparam logic [3:0] MAX_C20  = 4'd2;
    localparam logic [3:0] MAX_C10  = 4'd1;
    localparam logic [3:0] MAX_C5   = 4'd1;
    localparam logic [3:0] MAX_C1   = 4'd4;
    typedef enum logic {IDLE, COLLECT} state_e;
    function automatic logic [3:0] beat_max(input logic [2:0] idx);
        return idx == 3'd0 ? MAX_ITEM :
               idx == 3'd1 ? MAX_C50  :
               idx == 3'd2 ? MAX_C20  :
               idx == 3'd3 ? MAX_C10  :
               idx == 3'd4 ? MAX_C5   : MAX_C1;
    endfunction
endpackage

// File: rtl/vm_change_sum.sv
// vm_change_sum: weighted sum of the change coin counts.
module vm_change_sum
    import vm_pkg::*;
(
    input  logic [3:0] coin_50,
    input  logic [1:0] coin_20,
    input  logic       coin_10,
    input  logic       coin_5,
    input  logic [2:0] coin_1,
    output logic [8:0] change_total
);
    logic [9:0] sum;
    assign sum = 10'(coin_50) * DEN_50 + 10'(coin_20) * DEN_20 + 10'(coin_10) * DEN_10
               + 10'(coin_5) * DEN_5 + 10'(coin_1) * DEN_1;
    // Counts at their range limits can reach 559; clamp to the 9-bit ceiling of 511.
    assign change_total = sum[9] ? 9'd511 : sum[8:0];
endmodule

// File: rtl/vm_frame_rx.sv
// vm_frame_rx: collects 6-beat vending-machine result frames, range-checks them
// and publishes the decoded item, change coins and sold counts for good frames.
module vm_frame_rx
    import vm_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [3:0]       in_result,
    input  logic [5:0]       in_num,
    output logic             frame_valid,
    output logic             frame_err,
    output logic [2:0]       frame_item,
    output logic [3:0]       coin_50,
    output logic [1:0]       coin_20,
    output logic             coin_10,
    output logic             coin_5,
    output logic [2:0]       coin_1,
    output logic [8:0]       change_total,
    output logic [35:0]      sold_cnt,
    output logic [CNT_W-1:0] good_cnt
);
    localparam logic [2:0] LAST = 3'(FRAME_LEN - 1);
    state_e           state_q, state_d;
    logic [2:0]       idx_q, idx_d;
    logic             viol_q, viol_d;
    logic             fv_q, fv_d, fe_q, fe_d;
    logic [3:0]       res_q [FRAME_LEN-1];
    logic [5:0]       num_q [FRAME_LEN-1];
    logic [5:0]       sold_all [8];
    logic             beat_ok, last, item_bad;
    logic [2:0]       item_q;
    logic [3:0]       c50_q;
    logic [1:0]       c20_q;
    logic             c10_q, c5_q;
    logic [2:0]       c1_q;
    logic [35:0]      sold_q;
    logic [CNT_W-1:0] good_q;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        viol_d   = viol_q;
        sold_all = '{default: '0};
        for (int i = 0; i < FRAME_LEN - 1; i++) sold_all[i] = num_q[i];
        sold_all[FRAME_LEN-1] = in_num;
        beat_ok  = in_result <= beat_max(idx_q);
        last     = in_valid && state_q == COLLECT && idx_q == LAST;
        // The final beat is still on the inputs, so item 6's count comes from in_num.
        item_bad = res_q[0] != 4'd0 && res_q[0] <= MAX_ITEM && sold_all[res_q[0][2:0] - 3'd1] == 6'd0;
        fv_d     = last && !viol_q && beat_ok && !item_bad;
        fe_d     = (last && !fv_d) || (state_q == COLLECT && !in_valid);
        if (state_q == IDLE && in_valid) begin
            state_d = COLLECT;
            idx_d   = 3'd1;
            viol_d  = !beat_ok;
        end else if (state_q == COLLECT) begin
            state_d = (in_valid && !last) ? COLLECT : IDLE;
            idx_d   = (in_valid && !last) ? idx_q + 3'd1 : 3'd0;
            viol_d  = in_valid && !last && (viol_q || !beat_ok);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            viol_q  <= 1'b0;
            fv_q    <= 1'b0;
            fe_q    <= 1'b0;
            for (int i = 0; i < FRAME_LEN - 1; i++) begin
                res_q[i] <= '0;
                num_q[i] <= '0;
            end
            item_q  <= '0;
            c50_q   <= '0;
            c20_q   <= '0;
            c10_q   <= 1'b0;
            c5_q    <= 1'b0;
            c1_q    <= '0;
            sold_q  <= '0;
            good_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            viol_q  <= viol_d;
            fv_q    <= fv_d;
            fe_q    <= fe_d;
            if (in_valid && idx_q != LAST) begin
                res_q[idx_q] <= in_result;
                num_q[idx_q] <= in_num;
            end
            if (fv_d) begin
                item_q <= res_q[0][2:0];
                c50_q  <= res_q[1];
                c20_q  <= res_q[2][1:0];
                c10_q  <= res_q[3][0];
                c5_q   <= res_q[4][0];
                c1_q   <= in_result[2:0];
                for (int i = 0; i < NUM_ITEMS; i++) sold_q[6*i +: 6] <= sold_all[i];
                good_q <= good_q + CNT_W'(1);
            end
        end
    end

    vm_change_sum u_sum (
        .coin_50      (c50_q),
        .coin_20      (c20_q),
        .coin_10      (c10_q),
        .coin_5       (c5_q),
        .coin_1       (c1_q),
        .change_total (change_total)
    );

    assign frame_valid = fv_q;
    assign frame_err   = fe_q;
    assign frame_item  = item_q;
    assign coin_50     = c50_q;
    assign coin_20     = c20_q;
    assign coin_10     = c10_q;
    assign coin_5      = c5_q;
    assign coin_1      = c1_q;
    assign sold_cnt    = sold_q;
    assign good_cnt    = good_q;
endmodule

// File: tb/tb_vm_frame_rx.sv
// tb_vm_frame_rx: directed frame table, hand-written corner sequences and a
// random beat stream, all checked against a frame-level reference model.
module tb_vm_frame_rx;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic [3:0]  in_result = '0;
    logic [5:0]  in_num = '0;
    logic        frame_valid, frame_err, coin_10, coin_5;
    logic [2:0]  frame_item, coin_1;
    logic [3:0]  coin_50;
    logic [1:0]  coin_20;
    logic [8:0]  change_total;
    logic [35:0] sold_cnt;
    logic [7:0]  good_cnt;

    vm_frame_rx #(.CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_result(in_result), .in_num(in_num),
        .frame_valid(frame_valid), .frame_err(frame_err), .frame_item(frame_item),
        .coin_50(coin_50), .coin_20(coin_20), .coin_10(coin_10), .coin_5(coin_5), .coin_1(coin_1),
        .change_total(change_total), .sold_cnt(sold_cnt), .good_cnt(good_cnt)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0, cyc = 0;
    int lim[6] = '{6, 10, 2, 1, 1, 4};
    int q_res[$], q_num[$];
    int m_item, m_c[5], m_sold[6], m_good, m_fv, m_fe;

    typedef struct {
        int r[6];
        int n[6];
        int ok;
        int item;
        int total;
    } vec_t;
    vec_t tbl[8];

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic m_reset();
        q_res.delete(); q_num.delete();
        m_item = 0; m_good = 0; m_fv = 0; m_fe = 0;
        for (int i = 0; i < 5; i++) m_c[i] = 0;
        for (int i = 0; i < 6; i++) m_sold[i] = 0;
    endtask

    task automatic m_step(input int v, input int r, input int n);
        int ok;
        m_fv = 0; m_fe = 0;
        if (v != 0) begin
            q_res.push_back(r); q_num.push_back(n);
            if (q_res.size() == 6) begin
                ok = 1;
                for (int i = 0; i < 6; i++) if (q_res[i] > lim[i]) ok = 0;
                if (q_res[0] >= 1 && q_res[0] <= 6 && q_num[q_res[0]-1] == 0) ok = 0;
                if (ok != 0) begin
                    m_item = q_res[0];
                    for (int i = 0; i < 5; i++) m_c[i] = q_res[i+1];
                    for (int i = 0; i < 6; i++) m_sold[i] = q_num[i];
                    m_good = (m_good + 1) % 256;
                end
                m_fv = ok; m_fe = 1 - ok;
                q_res.delete(); q_num.delete();
            end
        end else if (q_res.size() > 0) begin
            m_fe = 1;
            q_res.delete(); q_num.delete();
        end
    endtask

    task automatic compare_all();
        longint s = 0;
        int tot;
        for (int i = 0; i < 6; i++) s |= longint'(m_sold[i]) << (6 * i);
        tot = 50 * m_c[0] + 20 * m_c[1] + 10 * m_c[2] + 5 * m_c[3] + m_c[4];
        if (tot > 511) tot = 511;
        chk("frame_valid", frame_valid, m_fv);
        chk("frame_err", frame_err, m_fe);
        chk("frame_item", frame_item, m_item);
        chk("coin_50", coin_50, m_c[0]);
        chk("coin_20", coin_20, m_c[1]);
        chk("coin_10", coin_10, m_c[2]);
        chk("coin_5", coin_5, m_c[3]);
        chk("coin_1", coin_1, m_c[4]);
        chk("change_total", change_total, tot);
        chk("sold_cnt", sold_cnt, s);
        chk("good_cnt", good_cnt, m_good);
    endtask

    task automatic cycle(input int v, input int r, input int n);
        in_valid = v[0]; in_result = r[3:0]; in_num = n[5:0];
        m_step(v, r, n);
        @(posedge clk); #1;
        cyc++;
        compare_all();
    endtask

    initial begin
        int pg, pi, p1, p2, g0, b, v, r, n;
        tbl[0] = '{'{2, 1, 2, 0, 0, 3}, '{0, 3, 0, 0, 0, 0}, 1, 2, 93};
        tbl[1] = '{'{1, 0, 3, 0, 0, 0}, '{5, 0, 0, 0, 0, 0}, 0, 0, 0};
        tbl[2] = '{'{4, 0, 0, 0, 0, 0}, '{1, 1, 1, 0, 1, 1}, 0, 0, 0};
        tbl[3] = '{'{0, 10, 2, 1, 1, 4}, '{0, 0, 0, 0, 0, 0}, 1, 0, 511};
        tbl[4] = '{'{6, 0, 0, 0, 0, 0}, '{1, 1, 1, 1, 1, 0}, 0, 0, 0};
        tbl[5] = '{'{6, 0, 0, 0, 0, 0}, '{0, 0, 0, 0, 0, 7}, 1, 6, 0};
        tbl[6] = '{'{7, 0, 0, 0, 0, 0}, '{1, 1, 1, 1, 1, 1}, 0, 0, 0};
        tbl[7] = '{'{3, 2, 1, 1, 0, 4}, '{0, 0, 9, 0, 0, 0}, 1, 3, 134};
        m_reset();
        #2 rst_n = 1'b0;
        #1 compare_all();
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        // Directed frames, issued back to back with no idle beat between them.
        for (int i = 0; i < 8; i++) begin
            for (int k = 0; k < 6; k++) cycle(1, tbl[i].r[k], tbl[i].n[k]);
            chk($sformatf("tbl%0d_valid", i), frame_valid, tbl[i].ok);
            chk($sformatf("tbl%0d_err", i), frame_err, 1 - tbl[i].ok);
            if (tbl[i].ok != 0) begin
                chk($sformatf("tbl%0d_item", i), frame_item, tbl[i].item);
                chk($sformatf("tbl%0d_total", i), change_total, tbl[i].total);
            end
            if (i == 0) begin
                chk("tbl0_good_cnt", good_cnt, 1);
                chk("tbl0_sold_item2", sold_cnt[11:6], 3);
            end
        end
        cycle(0, 0, 0);

        // Partial frame: in_valid drops after beat 3.
        pg = good_cnt; pi = frame_item;
        for (int k = 0; k < 4; k++) cycle(1, 1, 5);
        cycle(0, 0, 0);
        chk("gap_err", frame_err, 1);
        chk("gap_no_valid", frame_valid, 0);
        chk("gap_good_hold", good_cnt, pg);
        chk("gap_item_hold", frame_item, pi);
        cycle(0, 0, 0);
        chk("gap_err_one_cycle", frame_err, 0);

        // Two frames over 12 continuous beats.
        p1 = -1; p2 = -1; g0 = good_cnt;
        for (int f = 0; f < 2; f++)
            for (int k = 0; k < 6; k++) begin
                cycle(1, (k == 0) ? 5 : 0, 2);
                if (frame_valid) begin if (p1 < 0) p1 = cyc; else p2 = cyc; end
            end
        cycle(0, 0, 0);
        if (frame_valid) p2 = cyc;
        chk("b2b_first_seen", p1 >= 0, 1);
        chk("b2b_spacing", p2 - p1, 6);
        chk("b2b_good_cnt", good_cnt, (g0 + 2) % 256);

        // Reset asserted in the middle of beat 2.
        cycle(1, 2, 0);
        cycle(1, 1, 3);
        in_valid = 1'b1; in_result = 4'd2; in_num = 6'd0;
        #2 rst_n = 1'b0;
        in_valid = 1'b0;
        m_reset();
        #1 compare_all();
        @(posedge clk); #1 compare_all();
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) cycle(1, tbl[0].r[k], tbl[0].n[k]);
        chk("rst_frame_valid", frame_valid, 1);
        chk("rst_frame_total", change_total, 93);
        chk("rst_frame_good", good_cnt, 1);

        // Random beat stream; long enough for good_cnt to wrap.
        for (int c = 0; c < 5000; c++) begin
            v = ($urandom % 50 != 0) ? 1 : 0;
            b = q_res.size();
            r = ($urandom % 25 == 0) ? int'($urandom % 16) : int'($urandom_range(0, lim[b]));
            n = ($urandom % 10 == 0) ? 0 : int'($urandom % 64);
            cycle(v, r, n);
        end
        cycle(0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
